// File: rtl/uart_rxbuf.sv
// -----------------------------------------------------------------------------
// uart_rxbuf
//
// Receive-side byte buffer placed directly behind the UART. Every byte the
// UART offers (rx_avail) is popped in the same cycle (rx_re = rx_avail) and
// written into a DEPTH-entry circular FIFO. The head of the FIFO is presented
// to the consumer through a valid/ready handshake. When the FIFO is full and
// nothing leaves in the same cycle, the incoming byte is discarded and the
// sticky ovf flag is set; intake never stalls, so the UART never overruns.
//
// Handshake (out_*): out_valid is a pure function of registered state (FIFO
// not empty) and never depends on out_ready. A transfer happens on a rising
// clk edge where out_valid && out_ready are both 1. While out_valid is high
// and out_ready is low, out_data holds steady.
//
// Optional build macro: UART_RXBUF_ECHO_EN
//   Defined   : each accepted byte with tx_avail == 1 at accept time is sent
//               back to the UART transmitter as a 1-cycle tx_we pulse on the
//               following cycle, with tx_data holding that byte.
//   Undefined : tx_avail is ignored, tx_we and tx_data are tied to 0.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, >= 2 (default 16)
//   AW        pointer width, $clog2(DEPTH); derived, not overridden
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx_avail   in   UART has a byte on rx_data
//   rx_data    in   UART received byte
//   rx_re      out  pops the UART byte (follows rx_avail)
//   out_valid  out  head byte valid
//   out_ready  in   consumer accepts head byte
//   out_data   out  head byte
//   level      out  occupancy 0..DEPTH
//   full       out  level == DEPTH
//   empty      out  level == 0
//   ovf        out  sticky overflow flag
//   ovf_clr    in   clears ovf (a drop in the same cycle wins)
//   tx_avail   in   UART transmitter can accept a byte (echo build)
//   tx_we      out  UART transmit write strobe (echo build)
//   tx_data    out  UART transmit byte (echo build)
// -----------------------------------------------------------------------------
module uart_rxbuf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_avail,
  input  logic [7:0]    rx_data,
  output logic          rx_re,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          tx_avail,
  output logic          tx_we,
  output logic [7:0]    tx_data
);

  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;

  // Per-cycle events
  logic wr;    // incoming byte is stored
  logic pop;   // head byte leaves
  logic drop;  // incoming byte is discarded (full, nothing leaving)

  // ---------------------------------------------------------------------------
  // Flags and output view, all derived from registered state
  // ---------------------------------------------------------------------------
  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign out_valid = !empty;
  assign out_data  = mem_q[rp_q];

  // The UART is drained unconditionally, even during reset.
  assign rx_re = rx_avail;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pop  = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr   = rx_avail && (!full || pop);
    drop = rx_avail && full && !pop;

    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;

    if (wr) begin
      mem_d[wp_q] = rx_data;
      wp_d        = wp_q + PTR_ONE;  // wraps modulo DEPTH (power of two)
    end

    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end

    unique case ({wr, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through level/rp.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Echo path
  // ---------------------------------------------------------------------------
`ifdef UART_RXBUF_ECHO_EN
  logic       tx_we_q, tx_we_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    // Only stored bytes are echoed, and only if the transmitter is free at
    // accept time; there is no retry.
    if (wr && tx_avail) begin
      tx_we_d   = 1'b1;
      tx_data_d = rx_data;
    end else begin
      tx_we_d   = 1'b0;
      tx_data_d = tx_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_we_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_we   = tx_we_q;
  assign tx_data = tx_data_q;
`else
  logic unused_tx_avail;
  assign unused_tx_avail = tx_avail;
  assign tx_we           = 1'b0;
  assign tx_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rxbuf.sv
// -----------------------------------------------------------------------------
// tb_uart_rxbuf
//
// Directed bench for uart_rxbuf (DEPTH = 16). A queue-based reference model
// (exp_q holds the bytes that must be in the buffer, head first) is advanced
// on every rising edge from the inputs; a compare process checks every DUT
// output against it on each falling edge. Literal checks in the directed
// sequence pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rxbuf;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic          rx_avail  = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          rx_re;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          ovf_clr   = 1'b0;
  logic          tx_avail  = 1'b0;
  logic          tx_we;
  logic [7:0]    tx_data;

  uart_rxbuf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_avail  (rx_avail),
    .rx_data   (rx_data),
    .rx_re     (rx_re),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .tx_avail  (tx_avail),
    .tx_we     (tx_we),
    .tx_data   (tx_data)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  bit         m_ovf   = 1'b0;
  bit         m_tx_we = 1'b0;
  logic [7:0] m_tx_d  = 8'h00;

  always @(posedge clk) begin
    bit m_pop, m_wr;
    if (rst) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_tx_we = 1'b0;
      m_tx_d  = 8'h00;
    end else begin
      m_pop = (exp_q.size() > 0) && out_ready;
      m_wr  = rx_avail && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (m_wr)  exp_q.push_back(rx_data);
      if (rx_avail && !m_wr) m_ovf = 1'b1;
      else if (ovf_clr)      m_ovf = 1'b0;
`ifdef UART_RXBUF_ECHO_EN
      m_tx_we = m_wr && tx_avail;
      if (m_tx_we) m_tx_d = rx_data;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and output capture
  // ---------------------------------------------------------------------------
  logic [7:0] got_q[$];
  int         max_level = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_re",     {31'b0, rx_re},     {31'b0, rx_avail});
      check("level",     {27'b0, level},     exp_q.size());
      check("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() > 0)});
      check("empty",     {31'b0, empty},     {31'b0, (exp_q.size() == 0)});
      check("full",      {31'b0, full},      {31'b0, (exp_q.size() == DEPTH)});
      check("ovf",       {31'b0, ovf},       {31'b0, m_ovf});
      if (exp_q.size() > 0) check("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
      check("tx_we",     {31'b0, tx_we},     {31'b0, m_tx_we});
      check("tx_data",   {24'b0, tx_data},   {24'b0, m_tx_d});
      if (!rst && out_valid && out_ready) got_q.push_back(out_data);
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      rx_avail  = 1'b1;
      rx_data   = base + 8'(i);
      out_ready = rdy;
      tick();
    end
    rx_avail  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  task automatic check_got(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check(name, {24'b0, got_q[i]}, {24'b0, exp[i]});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] e[$];

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_level", {27'b0, level}, 0);
    check("rst_empty", {31'b0, empty}, 1);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_ovf",   {31'b0, ovf}, 0);

    // Single byte
    rx_avail = 1'b1; rx_data = 8'h41; out_ready = 1'b0;
    #1 check("single_rx_re", {31'b0, rx_re}, 1);
    tick();
    rx_avail = 1'b0;
    check("single_valid", {31'b0, out_valid}, 1);
    check("single_data",  {24'b0, out_data}, 32'h41);
    check("single_level", {27'b0, level}, 1);
    drain(1);
    check("single_empty", {31'b0, empty}, 1);
    check("single_level0", {27'b0, level}, 0);

    // Fill and overflow
    push_bytes(8'h00, 16, 1'b0);
    check("fill_full",  {31'b0, full}, 1);
    check("fill_level", {27'b0, level}, 16);
    rx_avail = 1'b1; rx_data = 8'hFF;
    #1 check("drop_rx_re", {31'b0, rx_re}, 1);
    tick();
    rx_avail = 1'b0;
    check("drop_ovf",   {31'b0, ovf}, 1);
    check("drop_level", {27'b0, level}, 16);
    got_q.delete();
    drain(16);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(8'(i));
    check_got("fill_order", e);

    // Simultaneous write and pop at full
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("clr_ovf", {31'b0, ovf}, 0);
    push_bytes(8'h80, 16, 1'b0);
    rx_avail = 1'b1; rx_data = 8'h55; out_ready = 1'b1;
    tick();
    rx_avail = 1'b0; out_ready = 1'b0;
    check("simul_level", {27'b0, level}, 16);
    check("simul_ovf",   {31'b0, ovf}, 0);
    check("simul_head",  {24'b0, out_data}, 32'h81);
    got_q.delete();
    drain(16);
    e.delete();
    for (int i = 1; i < 16; i++) e.push_back(8'h80 + 8'(i));
    e.push_back(8'h55);
    check_got("simul_order", e);

    // Wrap: streaming with consumer always ready
    got_q.delete();
    max_level = 0;
    rx_avail = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(i);
      tick();
    end
    rx_avail = 1'b0;
    tick();
    out_ready = 1'b0;
    e.delete();
    for (int i = 0; i < 40; i++) e.push_back(8'(i));
    check_got("wrap_order", e);
    check("wrap_max_level", max_level, 1);
    check("wrap_ovf", {31'b0, ovf}, 0);

    // Flag precedence: clear and drop in the same cycle
    push_bytes(8'hA0, 16, 1'b0);
    rx_avail = 1'b1; rx_data = 8'hEE; ovf_clr = 1'b1;
    tick();
    rx_avail = 1'b0; ovf_clr = 1'b0;
    check("prec_ovf", {31'b0, ovf}, 1);

    // Reset mid-stream with level = 5
    drain(16);
    push_bytes(8'h30, 5, 1'b0);
    check("pre_rst_level", {27'b0, level}, 5);
    rx_avail = 1'b1; rx_data = 8'h99; rst = 1'b1;
    #1 check("rst_rx_re", {31'b0, rx_re}, 1);
    tick();
    rx_avail = 1'b0; rst = 1'b0;
    check("midrst_level", {27'b0, level}, 0);
    check("midrst_empty", {31'b0, empty}, 1);
    check("midrst_ovf",   {31'b0, ovf}, 0);

`ifdef UART_RXBUF_ECHO_EN
    // Echo
    rx_avail = 1'b1; rx_data = 8'h0D; tx_avail = 1'b1;
    tick();
    rx_avail = 1'b0; tx_avail = 1'b0;
    check("echo_we",   {31'b0, tx_we}, 1);
    check("echo_data", {24'b0, tx_data}, 32'h0D);
    tick();
    check("echo_pulse_end", {31'b0, tx_we}, 0);
    rx_avail = 1'b1; rx_data = 8'h0A; tx_avail = 1'b0;
    tick();
    rx_avail = 1'b0;
    check("noecho_we", {31'b0, tx_we}, 0);
    tick();
    check("noecho_we2", {31'b0, tx_we}, 0);
`else
    rx_avail = 1'b1; rx_data = 8'h0D; tx_avail = 1'b1;
    tick();
    rx_avail = 1'b0; tx_avail = 1'b0;
    check("noecho_build_we",   {31'b0, tx_we}, 0);
    check("noecho_build_data", {24'b0, tx_data}, 0);
`endif

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
